wb_interconnect: RTL and testbench

WB_INTERCONNECT -- requirements
Module: wb_interconnect

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_rr_arbiter.sv | 27 ++
 rtl/wb_interconnect.sv | 159 +++++++++++++++
 tb/tb_wb_interconnect.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone interconnect definitions: CTI codes, FSM states and the default
// slave address map.
package wb_pkg;

    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiConst   = 3'b001;
    localparam logic [2:0] CtiIncr    = 3'b010;
    localparam logic [2:0] CtiEnd     = 3'b111;

    typedef enum logic [0:0] {
        StIdle,
        StOwned
    } wb_state_e;

    localparam int unsigned MaxPorts = 8;

    // Slave k sits at k * 64 KiB; only the first NUM_S entries are used.
    localparam logic [MaxPorts-1:0][31:0] DefaultBase = {
        32'h0007_0000, 32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
        32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000
    };
    localparam logic [MaxPorts-1:0][31:0] DefaultMask = {MaxPorts{32'hFFFF_0000}};

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker: first requester after `last_i`, wrapping.
module wb_rr_arbiter #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned IdxW  = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IdxW-1:0]  last_i,
    output logic [IdxW-1:0]  grant_o,
    output logic             valid_o
);

    int unsigned idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= NUM_M; i++) begin
            idx = (int'(last_i) + i) % NUM_M;
            if (!valid_o && req_i[idx[IdxW-1:0]]) begin
                valid_o = 1'b1;
                grant_o = idx[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_interconnect.sv
// Shared-bus Wishbone interconnect: one owner at a time, round-robin arbitration,
// address decode, unmapped-address and timeout bus errors.
module wb_interconnect
    import wb_pkg::*;
#(
    parameter int unsigned               NUM_M   = 2,
    parameter int unsigned               NUM_S   = 2,
    parameter int unsigned               TIMEOUT = 255,
    parameter logic [NUM_S-1:0][31:0]    S_BASE  = DefaultBase[NUM_S-1:0],
    parameter logic [NUM_S-1:0][31:0]    S_MASK  = DefaultMask[NUM_S-1:0]
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_M-1:0]             m_cyc,
    input  logic [NUM_M-1:0]             m_stb,
    input  logic [NUM_M-1:0]             m_we,
    input  logic [NUM_M-1:0][31:0]       m_adr,
    input  logic [NUM_M-1:0][31:0]       m_dat_w,
    input  logic [NUM_M-1:0][2:0]        m_cti,
    output logic [NUM_M-1:0]             m_ack,
    output logic [NUM_M-1:0]             m_err,
    output logic [NUM_M-1:0]             m_rty,
    output logic [NUM_M-1:0][31:0]       m_dat_r,
    output logic [NUM_S-1:0]             s_cyc,
    output logic [NUM_S-1:0]             s_stb,
    output logic [NUM_S-1:0]             s_we,
    output logic [NUM_S-1:0][31:0]       s_adr,
    output logic [NUM_S-1:0][31:0]       s_dat_w,
    output logic [NUM_S-1:0][2:0]        s_cti,
    input  logic [NUM_S-1:0]             s_ack,
    input  logic [NUM_S-1:0]             s_err,
    input  logic [NUM_S-1:0]             s_rty,
    input  logic [NUM_S-1:0][31:0]       s_dat_r
);

    localparam int unsigned MIdxW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned SIdxW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

    wb_state_e        state_q, state_d;
    logic [MIdxW-1:0] grant_q, grant_d;
    logic [MIdxW-1:0] last_q, last_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [MIdxW-1:0] arb_idx;
    logic             arb_valid;
    logic             owned;
    logic             stb_g;
    logic [31:0]      adr_g;
    logic             hit;
    logic [SIdxW-1:0] sel;
    logic             resp;
    logic             timeout;

    wb_rr_arbiter #(
        .NUM_M (NUM_M),
        .IdxW  (MIdxW)
    ) u_arb (
        .req_i   (m_cyc),
        .last_i  (last_q),
        .grant_o (arb_idx),
        .valid_o (arb_valid)
    );

    // Ownership is gated by reset and the live CYC so an abort takes effect this cycle.
    assign owned   = rst && (state_q == StOwned) && m_cyc[grant_q];
    assign stb_g   = m_stb[grant_q];
    assign adr_g   = m_adr[grant_q];
    assign timeout = (cnt_q == 16'(TIMEOUT));

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if ((adr_g & S_MASK[i]) == S_BASE[i]) begin
                hit = 1'b1;
                sel = SIdxW'(i);
            end
        end
    end

    assign resp = hit && (s_ack[sel] || s_err[sel] || s_rty[sel]);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StOwned;
                    grant_d = arb_idx;
                end
            end
            StOwned: begin
                if (!m_cyc[grant_q]) begin
                    state_d = StIdle;
                    last_d  = grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (owned && stb_g && hit && !resp && !timeout) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        s_cyc   = '0;
        s_stb   = '0;
        s_we    = '0;
        s_adr   = '0;
        s_dat_w = '0;
        s_cti   = '0;
        m_ack   = '0;
        m_err   = '0;
        m_rty   = '0;
        m_dat_r = '0;
        if (owned) begin
            if (hit) begin
                s_cyc[sel]   = 1'b1;
                s_stb[sel]   = stb_g && !timeout;
                s_we[sel]    = m_we[grant_q];
                s_adr[sel]   = adr_g;
                s_dat_w[sel] = m_dat_w[grant_q];
                s_cti[sel]   = m_cti[grant_q];
                if (timeout) begin
                    m_err[grant_q] = stb_g;
                end else begin
                    m_ack[grant_q]   = s_ack[sel];
                    m_err[grant_q]   = s_err[sel];
                    m_rty[grant_q]   = s_rty[sel];
                    m_dat_r[grant_q] = s_dat_r[sel];
                end
            end else begin
                m_err[grant_q] = stb_g;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= MIdxW'(NUM_M - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: slave-side beats are checked against a
// scoreboard, master-side responses with immediate assertions.
module tb_wb_interconnect;
    import wb_pkg::*;

    localparam logic [31:0] S0Dat = 32'hA5A5_0000;
    localparam logic [31:0] S1Dat = 32'h5A5A_0001;

    typedef struct {
        int          slv;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } beat_t;

    logic             clk;
    logic             rst;
    logic [1:0]       m_cyc, m_stb, m_we, m_ack, m_err, m_rty;
    logic [1:0][31:0] m_adr, m_dat_w, m_dat_r;
    logic [1:0][2:0]  m_cti;
    logic [1:0]       s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
    logic [1:0][31:0] s_adr, s_dat_w, s_dat_r;
    logic [1:0][2:0]  s_cti;

    beat_t sb[$];
    int    total;
    int    bad;

    wb_interconnect #(
        .NUM_M   (2),
        .NUM_S   (2),
        .TIMEOUT (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_dat_w (m_dat_w),
        .m_cti   (m_cti),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rty   (m_rty),
        .m_dat_r (m_dat_r),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_dat_w (s_dat_w),
        .s_cti   (s_cti),
        .s_ack   (s_ack),
        .s_err   (s_err),
        .s_rty   (s_rty),
        .s_dat_r (s_dat_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop one expected beat for every slave beat that completes this cycle.
    task automatic mon();
        beat_t e;
        for (int i = 0; i < 2; i++) begin
            if (s_stb[1'(i)] && s_ack[1'(i)]) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", 32'(s_stb[1'(i)]), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_slave", 32'(i), 32'(e.slv));
                    chk("sb_adr", s_adr[1'(i)], e.adr);
                    chk("sb_we", 32'(s_we[1'(i)]), 32'(e.we));
                    if (e.we) chk("sb_dat", s_dat_w[1'(i)], e.dat);
                end
            end
        end
    endtask

    task automatic sample();
        #3;
    endtask

    task automatic advance();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        m_we  = '0;
        m_adr = '0;
        m_adr[0] = 32'h10;
        m_adr[1] = 32'h10;
        m_dat_w  = '0;
        m_cti    = '0;
        s_ack    = 2'b11;
        s_err    = '0;
        s_rty    = '0;
        s_dat_r[0] = S0Dat;
        s_dat_r[1] = S1Dat;

        // Reset with requests present: every output stays quiet.
        @(posedge clk);
        #1;
        sample();
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        chk("rst_m_ack", 32'(m_ack), 32'd0);
        chk("rst_m_err", 32'(m_err), 32'd0);
        chk("rst_s_adr0", s_adr[0], 32'd0);
        chk("rst_m_dat_r0", m_dat_r[0], 32'd0);
        m_cyc = '0;
        m_stb = '0;
        advance();
        rst = 1'b1;

        // Contention straight after reset: m0 first, dead cycle, then m1.
        m_cyc = 2'b11;
        m_stb = 2'b11;
        m_adr[0] = 32'h0000_0020;
        m_adr[1] = 32'h0001_0004;
        sample();
        chk("arb_latency", 32'(s_cyc), 32'd0);
        advance();
        sb.push_back('{0, 32'h0000_0020, 32'h0, 1'b0});
        sample();
        chk("cont_m0_stb", 32'(s_stb), 32'd1);
        chk("cont_m0_ack", 32'(m_ack), 32'd1);
        chk("cont_m0_dat", m_dat_r[0], S0Dat);
        chk("cont_m1_dat", m_dat_r[1], 32'd0);
        advance();
        m_cyc = 2'b10;
        m_stb = 2'b10;
        sample();
        chk("drop_s_cyc", 32'(s_cyc), 32'd0);
        advance();
        sample();
        chk("dead_cycle", 32'(s_cyc), 32'd0);
        advance();
        sb.push_back('{1, 32'h0001_0004, 32'h0, 1'b0});
        sample();
        chk("cont_m1_stb", 32'(s_stb), 32'd2);
        chk("cont_m1_ack", 32'(m_ack), 32'd2);
        chk("cont_m1_dat", m_dat_r[1], S1Dat);
        advance();
        m_cyc = '0;
        m_stb = '0;
        cyc();
        cyc();

        // Single write from m0 to slave 0.
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_we  = 2'b01;
        m_adr[0]   = 32'h0000_0010;
        m_dat_w[0] = 32'hDEAD_BEEF;
        m_cti[0]   = CtiClassic;
        sample();
        chk("wr_latency", 32'(s_cyc), 32'd0);
        advance();
        sb.push_back('{0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1});
        sample();
        chk("wr_s_stb", 32'(s_stb), 32'd1);
        chk("wr_s_dat", s_dat_w[0], 32'hDEAD_BEEF);
        chk("wr_m_ack", 32'(m_ack), 32'd1);
        advance();
        m_cyc = '0;
        m_stb = '0;
        cyc();
        cyc();

        // m1 holds the bus through a 4-beat INCR burst while m0 waits.
        m_cyc = 2'b11;
        m_stb = 2'b11;
        m_we  = 2'b11;
        m_adr[0]   = 32'h0000_0030;
        m_dat_w[0] = 32'hC0C0_C0C0;
        m_adr[1]   = 32'h0001_0000;
        m_dat_w[1] = 32'h1000_0000;
        m_cti[1]   = CtiIncr;
        sample();
        chk("burst_latency", 32'(s_cyc), 32'd0);
        advance();
        for (int k = 0; k < 4; k++) begin
            m_adr[1]   = 32'h0001_0000 + 32'(4 * k);
            m_dat_w[1] = 32'h1000_0000 + 32'(k);
            m_cti[1]   = (k == 3) ? CtiEnd : CtiIncr;
            sb.push_back('{1, m_adr[1], m_dat_w[1], 1'b1});
            sample();
            chk("burst_s_stb", 32'(s_stb), 32'd2);
            chk("burst_m_ack", 32'(m_ack), 32'd2);
            chk("burst_s_cti", 32'(s_cti[1]), 32'(m_cti[1]));
            advance();
        end
        m_cyc = 2'b01;
        m_stb = 2'b01;
        sample();
        chk("burst_release", 32'(s_cyc), 32'd0);
        advance();
        sample();
        chk("burst_dead", 32'(s_cyc), 32'd0);
        advance();
        sb.push_back('{0, 32'h0000_0030, 32'hC0C0_C0C0, 1'b1});
        sample();
        chk("burst_m0_stb", 32'(s_stb), 32'd1);
        chk("burst_m0_ack", 32'(m_ack), 32'd1);
        advance();
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        cyc();
        cyc();

        // Unmapped address: immediate error, no slave strobed.
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_adr[0] = 32'h0002_0000;
        cyc();
        sample();
        chk("unm_err", 32'(m_err), 32'd1);
        chk("unm_s_stb", 32'(s_stb), 32'd0);
        chk("unm_ack", 32'(m_ack), 32'd0);
        advance();
        m_cyc = '0;
        m_stb = '0;
        cyc();
        cyc();

        // Timeout: slave 0 never answers.
        s_ack = 2'b10;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_adr[0] = 32'h0000_0040;
        cyc();
        sample();
        chk("to_first_stb", 32'(s_stb), 32'd1);
        chk("to_first_err", 32'(m_err), 32'd0);
        advance();
        for (int k = 1; k < 8; k++) begin
            sample();
            chk("to_wait_stb", 32'(s_stb), 32'd1);
            chk("to_wait_err", 32'(m_err), 32'd0);
            advance();
        end
        sample();
        chk("to_err", 32'(m_err), 32'd1);
        chk("to_stb_low", 32'(s_stb), 32'd0);
        advance();
        sample();
        chk("to_restart_stb", 32'(s_stb), 32'd1);
        chk("to_restart_err", 32'(m_err), 32'd0);
        advance();
        m_cyc = '0;
        m_stb = '0;
        s_ack = 2'b11;
        cyc();
        cyc();

        // Reset during beat 2 of an m1 burst; m0 must win afterwards.
        m_cyc = 2'b11;
        m_stb = 2'b11;
        m_we  = 2'b10;
        m_adr[0]   = 32'h0000_0050;
        m_adr[1]   = 32'h0001_0000;
        m_dat_w[1] = 32'h2000_0000;
        m_cti[1]   = CtiIncr;
        cyc();
        sb.push_back('{1, 32'h0001_0000, 32'h2000_0000, 1'b1});
        sample();
        chk("rb_beat1_stb", 32'(s_stb), 32'd2);
        advance();
        m_adr[1]   = 32'h0001_0004;
        m_dat_w[1] = 32'h2000_0001;
        rst = 1'b0;
        sample();
        chk("rb_abort_s_cyc", 32'(s_cyc), 32'd0);
        chk("rb_abort_m_ack", 32'(m_ack), 32'd0);
        advance();
        rst = 1'b1;
        sample();
        chk("rb_idle_s_cyc", 32'(s_cyc), 32'd0);
        chk("rb_idle_m_ack", 32'(m_ack), 32'd0);
        advance();
        sb.push_back('{0, 32'h0000_0050, 32'h0, 1'b0});
        sample();
        chk("rb_m0_stb", 32'(s_stb), 32'd1);
        chk("rb_m0_ack", 32'(m_ack), 32'd1);
        advance();
        m_cyc = '0;
        m_stb = '0;
        cyc();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
